// File: rtl/alu_issue_stage.sv
// alu_issue_stage: execute-stage front end that encodes MIPS ops for an external ALU and registers its result toward MEM.
// Ports: clk/rst (sync, active-high), flush (kills both stages);
//   in_*  : decoded ID fields with in_valid/in_ready handshake;
//   alu_* : op/operands driven from stage A, result/zero/overflow consumed back;
//   out_* : stage B result, destination, write enable, branch outcome, exception flags with out_valid/out_ready.
// Build option: define OVF_TRAP_EN to raise out_ovf on signed ADD/ADDI/SUB overflow and suppress write-back.
module alu_issue_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         in_opcode,
  input  logic [5:0]         in_funct,
  input  logic [4:0]         in_shamt,
  input  logic [15:0]        in_imm,
  input  logic [XLEN-1:0]    in_rs_val,
  input  logic [XLEN-1:0]    in_rt_val,
  input  logic [RADDR_W-1:0] in_rt_addr,
  input  logic [RADDR_W-1:0] in_rd_addr,
  output logic [3:0]         alu_op,
  output logic [XLEN-1:0]    alu_rs,
  output logic [XLEN-1:0]    alu_rt,
  input  logic [XLEN-1:0]    alu_rd,
  input  logic               alu_zf,
  input  logic               alu_of,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic [RADDR_W-1:0] out_dest,
  output logic               out_wen,
  output logic               out_br_taken,
  output logic               out_ovf,
  output logic               out_ri
);
  typedef struct packed {
    logic [3:0]         op;
    logic [XLEN-1:0]    rs;
    logic [XLEN-1:0]    rt;
    logic [RADDR_W-1:0] dest;
    logic               wen;
    logic               br;
    logic               bne;
    logic               ri;
    logic               chk;
  } a_t;
  typedef struct packed {
    logic [XLEN-1:0]    result;
    logic [RADDR_W-1:0] dest;
    logic               wen;
    logic               br;
    logic               ovf;
    logic               ri;
  } b_t;
  a_t a_d, a_q;
  b_t b_d, b_q;
  logic a_valid_d, a_valid_q, out_valid_d, out_valid_q;
  logic b_free, accept, adv, ovf, wr;
  logic [XLEN-1:0] sext, zext;
  assign b_free   = !out_valid_q | out_ready;
  assign in_ready = !a_valid_q | b_free;
  assign accept   = in_valid & in_ready;
  assign adv      = a_valid_q & b_free;
  assign sext     = {{(XLEN-16){in_imm[15]}}, in_imm};
  assign zext     = {{(XLEN-16){1'b0}}, in_imm};
  // chk marks the signed ops whose ALU overflow flag is meaningful
  always_comb begin
    a_d      = '0;
    a_d.rs   = in_rs_val;
    a_d.rt   = in_rt_val;
    a_d.dest = in_rt_addr;
    wr       = 1'b1;
    case (in_opcode)
      6'h00: begin
        a_d.dest = in_rd_addr;
        case (in_funct)
          6'h20: begin a_d.op = 4'b1011; a_d.chk = 1'b1; end
          6'h21: a_d.op = 4'b0010;
          6'h22: begin a_d.op = 4'b1100; a_d.chk = 1'b1; end
          6'h23: a_d.op = 4'b0110;
          6'h24: a_d.op = 4'b0000;
          6'h25: a_d.op = 4'b0001;
          6'h26: a_d.op = 4'b0011;
          6'h27: a_d.op = 4'b0100;
          6'h2A: a_d.op = 4'b0111;
          6'h00, 6'h02, 6'h03: begin
            a_d.op = in_funct[1] ? (in_funct[0] ? 4'b1010 : 4'b1001) : 4'b1000;
            a_d.rs = in_rt_val;
            a_d.rt = {{(XLEN-5){1'b0}}, in_shamt};
          end
          default: begin wr = 1'b0; a_d.ri = 1'b1; end
        endcase
      end
      6'h08: begin a_d.op = 4'b1011; a_d.rt = sext; a_d.chk = 1'b1; end
      6'h09: begin a_d.op = 4'b0010; a_d.rt = sext; end
      6'h0A: begin a_d.op = 4'b0111; a_d.rt = sext; end
      6'h0C: begin a_d.op = 4'b0000; a_d.rt = zext; end
      6'h0D: begin a_d.op = 4'b0001; a_d.rt = zext; end
      6'h0E: begin a_d.op = 4'b0011; a_d.rt = zext; end
      6'h0F: begin a_d.op = 4'b1000; a_d.rs = zext; a_d.rt = XLEN'(16); end
      6'h04, 6'h05: begin a_d.op = 4'b0110; a_d.br = 1'b1; a_d.bne = in_opcode[0]; wr = 1'b0; end
      default: begin wr = 1'b0; a_d.ri = 1'b1; end
    endcase
    a_d.wen = wr & (a_d.dest != '0);
  end
`ifdef OVF_TRAP_EN
  assign ovf = a_q.chk & alu_of;
`else
  logic unused;
  assign unused = a_q.chk ^ alu_of;
  assign ovf    = 1'b0;
`endif
  // BEQ takes on zero, BNE on non-zero
  assign b_d         = {alu_rd, a_q.dest, a_q.wen & !ovf, a_q.br & (alu_zf ^ a_q.bne), ovf, a_q.ri};
  assign a_valid_d   = accept | (a_valid_q & !adv);
  assign out_valid_d = adv | (out_valid_q & !out_ready);
  always_ff @(posedge clk) begin
    if (rst | flush) begin
      a_valid_q   <= 1'b0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      a_valid_q   <= a_valid_d;
      out_valid_q <= out_valid_d;
      if (accept) a_q <= a_d;
      if (adv) b_q <= b_d;
    end
  end
  assign alu_op       = a_valid_q ? a_q.op : '0;
  assign alu_rs       = a_valid_q ? a_q.rs : '0;
  assign alu_rt       = a_valid_q ? a_q.rt : '0;
  assign out_valid    = out_valid_q;
  assign out_result   = b_q.result;
  assign out_dest     = b_q.dest;
  assign out_wen      = b_q.wen;
  assign out_br_taken = b_q.br;
  assign out_ovf      = b_q.ovf;
  assign out_ri       = b_q.ri;
endmodule
